// File: rtl/rf_write_arbiter_pkg.sv
// Shared writeback constants: requester count, register file widths and requester IDs.
package rf_write_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;

  // Fixed requester slots on the writeback port.
  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_LINK = 2'd2
  } req_id_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the requesters and the register file write port.
interface rf_write_arbiter_if #(
  parameter int unsigned NUM_REQ = rf_write_arbiter_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = rf_write_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W  = rf_write_arbiter_pkg::DATA_W
) ();

  logic                                stall;
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*ADDR_W-1:0]           req_addr;
  logic [NUM_REQ*DATA_W-1:0]           req_data;
  logic [NUM_REQ-1:0]                  gnt;
  logic                                writeEnable;
  logic [ADDR_W-1:0]                   writeAddr;
  logic [DATA_W-1:0]                   writeData;
  logic [rf_write_arbiter_pkg::CNT_W-1:0] writeCount;

  // Requester / pipeline side.
  modport master (
    output stall, req, req_addr, req_data,
    input  gnt, writeEnable, writeAddr, writeData, writeCount
  );

  // Arbiter side.
  modport slave (
    input  stall, req, req_addr, req_data,
    output gnt, writeEnable, writeAddr, writeData, writeCount
  );

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping upward.
module rr_pick
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = NUM_REQ,
  parameter int unsigned PtrW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] gnt
);

  logic [PtrW-1:0] idx;

  // Rotate the search start to ptr and keep only the first hit.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = PtrW'((32'(ptr) + k) % NumReq);
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register file write arbiter: round-robin grant, registered write port and commit counter.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ = rf_write_arbiter_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = rf_write_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W  = rf_write_arbiter_pkg::DATA_W
) (
  input logic                clk,
  input logic                rst,
  rf_write_arbiter_if.slave  bus
);

  import rf_write_arbiter_pkg::*;

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0] pick_gnt, gnt;
  logic [ADDR_W-1:0]  win_addr, addr_q, addr_d;
  logic [DATA_W-1:0]  win_data, data_q, data_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_pick #(
    .NumReq (NUM_REQ),
    .PtrW   (PtrW)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  // Suppress grants during reset or stall, then decode the single winner's slot.
  always_comb begin
    gnt      = (rst || bus.stall) ? '0 : pick_gnt;
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PtrW'(i);
        win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state: load the winner, but writes to index 0 are swallowed without a strobe.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (|gnt) begin
      ptr_d  = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PtrW'(1);
      we_d   = |win_addr;
      addr_d = win_addr;
      data_d = win_data;
      cnt_d  = we_d ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.gnt         = gnt;
  assign bus.writeEnable = we_q;
  assign bus.writeAddr   = addr_q;
  assign bus.writeData   = data_q;
  assign bus.writeCount  = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rf_write_arbiter;

  import rf_write_arbiter_pkg::*;

  localparam int N = NUM_REQ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  int                m_ptr = 0;
  logic              m_we  = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [CNT_W-1:0]  m_cnt  = '0;

  // Spec rule: no grant on rst/stall/idle, else first requester at or after p, modulo N.
  function automatic logic [N-1:0] exp_gnt(logic r, logic s, logic [N-1:0] q, int p);
    logic [N-1:0] v;
    v = '0;
    if (r || s || q == '0) return v;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (q[j]) begin
        v[j] = 1'b1;
        return v;
      end
    end
    return v;
  endfunction

  // Advance one clock edge and update the model from the inputs present before it.
  task automatic step();
    logic [N-1:0]      g;
    int                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    g = exp_gnt(rst, bus.stall, bus.req, m_ptr);
    w = -1;
    a = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        w = k;
        a = bus.req_addr[k*ADDR_W +: ADDR_W];
        d = bus.req_data[k*DATA_W +: DATA_W];
      end
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else if (w >= 0) begin
      m_ptr  = (w + 1) % N;
      m_we   = (a != '0);
      m_addr = a;
      m_data = d;
      if (m_we) m_cnt = m_cnt + 1'b1;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(int i, logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.req[i]                    = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, ADDR_W'(i + 1), 32'h1111 * (i + 1));
    #1;
    n_chk++; if (bus.gnt !== '0) $display("FAIL reset_gnt: got %b want 0", bus.gnt); else n_pass++;
    step();
    step();
    n_chk++; if (bus.writeEnable !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.writeEnable); else n_pass++;
    n_chk++; if (bus.writeAddr !== '0) $display("FAIL reset_addr: got %0h want 0", bus.writeAddr); else n_pass++;
    n_chk++; if (bus.writeData !== '0) $display("FAIL reset_data: got %0h want 0", bus.writeData); else n_pass++;
    n_chk++; if (bus.writeCount !== '0) $display("FAIL reset_cnt: got %0h want 0", bus.writeCount); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    rst = 1'b0;
    set_req(0, 1'b1, 5'd5, 32'hA);
    set_req(1, 1'b1, 5'd6, 32'hB);
    set_req(2, 1'b1, 5'd7, 32'hC);
    for (int k = 0; k < 3; k++) begin
      #1;
      e = '0; e[k] = 1'b1;
      n_chk++; if (bus.gnt !== e) $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, e); else n_pass++;
      step();
      bus.req[k] = 1'b0;
      n_chk++; if (bus.writeEnable !== 1'b1) $display("FAIL rr_we%0d: got %b want 1", k, bus.writeEnable); else n_pass++;
      n_chk++; if (bus.writeAddr !== ADDR_W'(5 + k)) $display("FAIL rr_addr%0d: got %0d want %0d", k, bus.writeAddr, 5 + k); else n_pass++;
      n_chk++; if (bus.writeData !== DATA_W'(10 + k)) $display("FAIL rr_data%0d: got %0h want %0h", k, bus.writeData, 10 + k); else n_pass++;
    end
    n_chk++; if (bus.writeCount !== 16'd3) $display("FAIL rr_cnt: got %0d want 3", bus.writeCount); else n_pass++;
    step();
    n_chk++; if (bus.writeEnable !== 1'b0) $display("FAIL idle_we: got %b want 0", bus.writeEnable); else n_pass++;
    n_chk++; if (bus.writeAddr !== 5'd7) $display("FAIL idle_hold_addr: got %0d want 7", bus.writeAddr); else n_pass++;
  endtask

  task automatic test_zero_index();
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    n_chk++; if (bus.gnt !== 3'b010) $display("FAIL zero_gnt: got %b want 010", bus.gnt); else n_pass++;
    step();
    bus.req = '0;
    n_chk++; if (bus.writeEnable !== 1'b0) $display("FAIL zero_we: got %b want 0", bus.writeEnable); else n_pass++;
    n_chk++; if (bus.writeCount !== 16'd3) $display("FAIL zero_cnt: got %0d want 3", bus.writeCount); else n_pass++;
  endtask

  task automatic test_stall();
    logic [N-1:0] e;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(1, 1'b1, 5'd2, 32'h200);
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (bus.gnt !== '0) $display("FAIL stall_gnt%0d: got %b want 0", k, bus.gnt); else n_pass++;
      step();
      n_chk++; if (bus.writeEnable !== 1'b0) $display("FAIL stall_we%0d: got %b want 0", k, bus.writeEnable); else n_pass++;
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k % 2 == 1) ? 3'b010 : 3'b001;
      n_chk++; if (bus.gnt !== e) $display("FAIL alt_gnt%0d: got %b want %b", k, bus.gnt, e); else n_pass++;
      step();
      n_chk++; if (bus.writeAddr !== ((k % 2 == 1) ? 5'd2 : 5'd1)) $display("FAIL alt_addr%0d: got %0d", k, bus.writeAddr); else n_pass++;
    end
    bus.req = '0;
  endtask

  task automatic test_ptr_wrap();
    // Last grant went to requester 1, so the pointer now sits at 2.
    set_req(0, 1'b1, 5'd9, 32'h900);
    set_req(2, 1'b1, 5'd10, 32'hA00);
    #1;
    n_chk++; if (bus.gnt !== 3'b100) $display("FAIL wrap_gnt_first: got %b want 100", bus.gnt); else n_pass++;
    step();
    bus.req[2] = 1'b0;
    #1;
    n_chk++; if (bus.gnt !== 3'b001) $display("FAIL wrap_gnt_second: got %b want 001", bus.gnt); else n_pass++;
    step();
    bus.req = '0;
    n_chk++; if (bus.writeAddr !== 5'd9) $display("FAIL wrap_addr: got %0d want 9", bus.writeAddr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 5'd3, 32'h333);
    #1;
    n_chk++; if (bus.gnt !== 3'b001) $display("FAIL mid_gnt: got %b want 001", bus.gnt); else n_pass++;
    step();
    rst = 1'b1;
    bus.req = 3'b010;
    #1;
    n_chk++; if (bus.gnt !== '0) $display("FAIL mid_rst_gnt: got %b want 0", bus.gnt); else n_pass++;
    n_chk++; if (bus.writeEnable !== 1'b1) $display("FAIL mid_we: got %b want 1", bus.writeEnable); else n_pass++;
    n_chk++; if (bus.writeAddr !== 5'd3) $display("FAIL mid_addr: got %0d want 3", bus.writeAddr); else n_pass++;
    step();
    n_chk++; if (bus.writeEnable !== 1'b0) $display("FAIL post_rst_we: got %b want 0", bus.writeEnable); else n_pass++;
    n_chk++; if (bus.writeAddr !== '0) $display("FAIL post_rst_addr: got %0d want 0", bus.writeAddr); else n_pass++;
    n_chk++; if (bus.writeData !== '0) $display("FAIL post_rst_data: got %0h want 0", bus.writeData); else n_pass++;
    n_chk++; if (bus.writeCount !== '0) $display("FAIL post_rst_cnt: got %0d want 0", bus.writeCount); else n_pass++;
    rst = 1'b0;
    bus.req = 3'b111;
    #1;
    n_chk++; if (bus.gnt !== 3'b001) $display("FAIL post_rst_ptr: got %b want 001", bus.gnt); else n_pass++;
    step();
    bus.req = '0;
  endtask

  task automatic test_random();
    bit                pend [N];
    logic [ADDR_W-1:0] pa   [N];
    logic [DATA_W-1:0] pd   [N];
    int                wt   [N];
    logic [N-1:0]      e;
    for (int i = 0; i < N; i++) begin pend[i] = 0; wt[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          pa[i]   = ADDR_W'($urandom_range(0, 31));
          pd[i]   = $urandom;
        end
        set_req(i, pend[i], pa[i], pd[i]);
      end
      bus.stall = ($urandom_range(0, 3) == 0);
      #1;
      e = exp_gnt(rst, bus.stall, bus.req, m_ptr);
      n_chk++; if (bus.gnt !== e) $display("FAIL rnd_gnt c%0d: got %b want %b", c, bus.gnt, e); else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && !bus.stall && !bus.gnt[i]) begin
          wt[i]++;
          n_chk++; if (wt[i] >= N) $display("FAIL rnd_starve r%0d: waited %0d want < %0d", i, wt[i], N); else n_pass++;
        end
        if (bus.gnt[i]) wt[i] = 0;
      end
      step();
      for (int i = 0; i < N; i++) if (e[i]) pend[i] = 0;
      n_chk++; if (bus.writeEnable !== m_we) $display("FAIL rnd_we c%0d: got %b want %b", c, bus.writeEnable, m_we); else n_pass++;
      n_chk++; if (bus.writeAddr !== m_addr) $display("FAIL rnd_addr c%0d: got %0d want %0d", c, bus.writeAddr, m_addr); else n_pass++;
      n_chk++; if (bus.writeData !== m_data) $display("FAIL rnd_data c%0d: got %0h want %0h", c, bus.writeData, m_data); else n_pass++;
      n_chk++; if (bus.writeCount !== m_cnt) $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, bus.writeCount, m_cnt); else n_pass++;
    end
    bus.req = '0;
    bus.stall = 1'b0;
  endtask

  task automatic test_count_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd4, 32'h444);
    for (int k = 0; k < 65535; k++) step();
    n_chk++; if (bus.writeCount !== 16'hFFFF) $display("FAIL cnt_full: got %0h want ffff", bus.writeCount); else n_pass++;
    step();
    n_chk++; if (bus.writeCount !== 16'h0000) $display("FAIL cnt_wrap: got %0h want 0", bus.writeCount); else n_pass++;
    n_chk++; if (bus.writeEnable !== 1'b1) $display("FAIL cnt_wrap_we: got %b want 1", bus.writeEnable); else n_pass++;
    bus.req = '0;
  endtask

  initial begin
    bus.stall    = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset();
    test_round_robin();
    test_zero_index();
    test_stall();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of writeback requesters (0 ALU, 1 load, 2 link).
REQ-002 Parameter ADDR_W, default 5: register index width.
REQ-003 Parameter DATA_W, default 32: register data width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 stall  input  1  when high, no grant is issued this cycle.
REQ-007 req  input  NUM_REQ  per-requester write request.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester destination index, slice i belongs to requester i.
REQ-009 req_data  input  NUM_REQ*DATA_W  per-requester write data, slice i belongs to requester i.
REQ-010 gnt  output  NUM_REQ  one-hot combinational grant; requester i's write is accepted at the edge ending a cycle with gnt[i]=1.
REQ-011 writeEnable  output  1  registered write strobe to the register file.
REQ-012 writeAddr  output  ADDR_W  registered destination index.
REQ-013 writeData  output  DATA_W  registered write data.
REQ-014 writeCount  output  16  registered count of committed non-zero-index writes, wraps 0xFFFF->0.

Function
REQ-015 gnt SHALL be all-zero when rst=1, when stall=1, or when req=0.
REQ-016 Otherwise gnt SHALL select the first requesting index at or after the round-robin pointer ptr, searching upward modulo NUM_REQ.
REQ-017 ptr SHALL advance to (granted index + 1) mod NUM_REQ on each granting edge and SHALL hold otherwise.
REQ-018 Requesters SHALL hold req, req_addr and req_data stable until granted; an ungranted requester SHALL never be dropped.
REQ-019 Starvation bound: a continuously requesting requester SHALL be granted within NUM_REQ non-stalled cycles.
REQ-020 Latency: on a granting edge the outputs SHALL load the winner's address and data, with writeEnable=1 for the following cycle only.
REQ-021 The negative-edge register file commits in that following cycle, half a clock after writeEnable rises.
REQ-022 A granted request to index 0 SHALL be accepted (gnt asserted) but SHALL produce writeEnable=0 and SHALL NOT increment writeCount.
REQ-023 With no grant, writeEnable SHALL be 0 next cycle and writeAddr/writeData SHALL hold their previous values.
REQ-024 A requester may deassert req on the granting edge and SHALL be free to reassert with new data the next cycle.
REQ-025 Simultaneous stall=1 and req SHALL yield no grant, no ptr change and writeEnable=0 next cycle.
REQ-026 writeCount SHALL increment by exactly 1 per committed writeEnable=1 cycle, at the same edge that loads that write.

Reset
REQ-027 When rst=1 at a rising edge: ptr=0, writeEnable=0, writeAddr=0, writeData=0, writeCount=0, and no request is accepted.
REQ-028 Assertion of rst mid-sequence SHALL discard any pending write; the write loaded before the rst edge still drives its cycle.
REQ-029 The first grant after reset release SHALL follow REQ-016 starting from ptr=0.

Structure
REQ-030 NUM_REQ, ADDR_W, DATA_W and requester IDs (REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2) SHALL live in the shared processor constants package.
REQ-031 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs req, ptr; output one-hot gnt); all state SHALL reside in rf_write_arbiter.

Verification
REQ-032 Reset then req=3'b111, addr={7,6,5}, data={C,B,A} held until each grant -> grants 0,1,2 on consecutive cycles; writeAddr 5,6,7 with writeEnable=1 on cycles 2-4; writeCount=3.
REQ-033 Requester 1 only, addr=0, data=0xDEADBEEF -> gnt[1]=1; writeEnable stays 0; writeCount unchanged.
REQ-034 req=3'b011 held continuously with stall=1 for 4 cycles -> gnt=0 and ptr=0 throughout; on release grants alternate 0,1,0,1.
REQ-035 ptr=2 with req=3'b101 -> requester 2 granted first, then 0.
REQ-036 rst pulsed on the edge after requester 0 grant (addr=3) -> that write (addr=3, writeEnable=1) completes its cycle; all outputs 0 next cycle; ptr=0.
REQ-037 writeCount preloaded to 0xFFFF by 65535 writes, then one more write -> writeCount=0x0000.
